// File: rtl/prim_subreg_pkg.sv
// Shared types for register-slice storage primitives.
// Software access policies understood by the subreg family.
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW,
        SwAccessWO,
        SwAccessRO,
        SwAccessW1S,
        SwAccessW1C,
        SwAccessW0C,
        SwAccessRC,
        SwAccessNone
    } sw_access_e;

endpackage

// File: rtl/prim_subreg_mhw.sv
// Register field storage with SW/HW write arbitration over NumHw HW ports.
// Lowest HW port index wins; same-cycle write collisions are flagged and counted.
module prim_subreg_mhw
    import prim_subreg_pkg::*;
#(
    parameter int unsigned     DW       = 32,
    parameter int unsigned     NumHw    = 2,
    parameter sw_access_e      SwAccess = SwAccessRW,
    parameter logic [DW-1:0]   RESVAL   = '0,
    parameter int unsigned     CntW     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we,
    input  logic [DW-1:0]       wd,
    input  logic [NumHw-1:0]    de,
    input  logic [NumHw*DW-1:0] d,
    output logic                qe,
    output logic [DW-1:0]       q,
    output logic [DW-1:0]       qs,
    output logic                collision_o,
    output logic [CntW-1:0]     collision_cnt_o,
    input  logic                collision_clr_i
);

    // RO and HW-only fields never see software writes.
    localparam bit SwWr = !((SwAccess == SwAccessRO) ||
                            (SwAccess == SwAccessNone));

    logic          sw_we;
    logic          hde;
    logic          multi;
    logic [DW-1:0] hd;
    logic [DW-1:0] base;
    logic [DW-1:0] nxt;
    logic          wr_en;
    logic          coll;

    assign sw_we = SwWr ? we : 1'b0;

    // Priority-select HW data: first set enable from index 0 wins.
    always_comb begin
        logic found;
        found = 1'b0;
        hde   = 1'b0;
        multi = 1'b0;
        hd    = '0;
        for (int i = 0; i < int'(NumHw); i++) begin
            if (de[i]) begin
                hde = 1'b1;
                if (found) begin
                    multi = 1'b1;
                end else begin
                    hd    = d[i*DW +: DW];
                    found = 1'b1;
                end
            end
        end
    end

    assign base = hde ? hd : q;

    // Merge software access semantics with the selected HW value.
    always_comb begin
        wr_en = sw_we | hde;
        nxt   = hd;
        case (SwAccess)
            SwAccessRW, SwAccessWO: begin
                nxt = sw_we ? wd : hd;
            end
            SwAccessW1S: begin
                nxt = base | (sw_we ? wd : '0);
            end
            SwAccessW1C: begin
                nxt = base & (sw_we ? ~wd : '1);
            end
            SwAccessW0C: begin
                nxt = base & (sw_we ? wd : '1);
            end
            SwAccessRC: begin
                nxt = sw_we ? '0 : base;
            end
            default: begin
                wr_en = hde;
                nxt   = hd;
            end
        endcase
    end

    assign coll = (sw_we & hde) | multi;

    // Read data is the stored value, so RC returns the pre-clear value.
    assign qs = q;

    // Field storage; holds unless some writer is active.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q <= RESVAL;
        end else if (wr_en) begin
            q <= nxt;
        end
    end

    // SW write strobe aligned with the cycle q shows the write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            qe <= 1'b0;
        end else begin
            qe <= sw_we;
        end
    end

    // Collision pulse and saturating counter; clear beats a new collision.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            collision_o     <= 1'b0;
            collision_cnt_o <= '0;
        end else begin
            collision_o <= coll;
            if (collision_clr_i) begin
                collision_cnt_o <= '0;
            end else if (coll && (collision_cnt_o != '1)) begin
                collision_cnt_o <= collision_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prim_subreg_mhw.sv
// Directed bench for prim_subreg_mhw across the SW access policies.
// Inputs are shared by all instances; each test checks the relevant one.
module tb_prim_subreg_mhw;
    import prim_subreg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [2:0]  de = '0;
    logic [95:0] d = '0;
    logic        clr = 1'b0;

    logic [31:0] rw_q, rw_qs, ro_q, ro_qs, s_q, s_qs;
    logic [31:0] c_q, c_qs, z_q, z_qs, rc_q, rc_qs, sat_q, sat_qs;
    logic        rw_qe, ro_qe, s_qe, c_qe, z_qe, rc_qe, sat_qe;
    logic        rw_co, ro_co, s_co, c_co, z_co, rc_co, sat_co;
    logic [7:0]  rw_cnt, ro_cnt, s_cnt, c_cnt, z_cnt, rc_cnt;
    logic [1:0]  sat_cnt;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    prim_subreg_mhw #(.DW(32), .NumHw(3), .SwAccess(SwAccessRW),
                      .RESVAL(32'hA5A5_0000), .CntW(8)) u_rw (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .wd(wd), .de(de), .d(d),
        .qe(rw_qe), .q(rw_q), .qs(rw_qs), .collision_o(rw_co),
        .collision_cnt_o(rw_cnt), .collision_clr_i(clr));

    prim_subreg_mhw #(.DW(32), .NumHw(3), .SwAccess(SwAccessRO),
                      .RESVAL(32'h0), .CntW(8)) u_ro (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .wd(wd), .de(de), .d(d),
        .qe(ro_qe), .q(ro_q), .qs(ro_qs), .collision_o(ro_co),
        .collision_cnt_o(ro_cnt), .collision_clr_i(clr));

    prim_subreg_mhw #(.DW(32), .NumHw(3), .SwAccess(SwAccessW1S),
                      .RESVAL(32'h0), .CntW(8)) u_w1s (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .wd(wd), .de(de), .d(d),
        .qe(s_qe), .q(s_q), .qs(s_qs), .collision_o(s_co),
        .collision_cnt_o(s_cnt), .collision_clr_i(clr));

    prim_subreg_mhw #(.DW(32), .NumHw(3), .SwAccess(SwAccessW1C),
                      .RESVAL(32'h0), .CntW(8)) u_w1c (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .wd(wd), .de(de), .d(d),
        .qe(c_qe), .q(c_q), .qs(c_qs), .collision_o(c_co),
        .collision_cnt_o(c_cnt), .collision_clr_i(clr));

    prim_subreg_mhw #(.DW(32), .NumHw(3), .SwAccess(SwAccessW0C),
                      .RESVAL(32'h0), .CntW(8)) u_w0c (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .wd(wd), .de(de), .d(d),
        .qe(z_qe), .q(z_q), .qs(z_qs), .collision_o(z_co),
        .collision_cnt_o(z_cnt), .collision_clr_i(clr));

    prim_subreg_mhw #(.DW(32), .NumHw(3), .SwAccess(SwAccessRC),
                      .RESVAL(32'h0), .CntW(8)) u_rc (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .wd(wd), .de(de), .d(d),
        .qe(rc_qe), .q(rc_q), .qs(rc_qs), .collision_o(rc_co),
        .collision_cnt_o(rc_cnt), .collision_clr_i(clr));

    prim_subreg_mhw #(.DW(32), .NumHw(3), .SwAccess(SwAccessRW),
                      .RESVAL(32'h0), .CntW(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .we(we), .wd(wd), .de(de), .d(d),
        .qe(sat_qe), .q(sat_q), .qs(sat_qs), .collision_o(sat_co),
        .collision_cnt_o(sat_cnt), .collision_clr_i(clr));

    task automatic drive(input logic w, input logic [31:0] wdat,
                         input logic [2:0] e, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic c);
        we  = w;
        wd  = wdat;
        de  = e;
        d   = {d2, d1, d0};
        clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 3'b011, 32'h1234, 32'h5678, 0, 1'b0);
        tick();
        tick();
        ncmp++; if (rw_q !== 32'hA5A5_0000) begin nerr++;
            $display("FAIL reset_q: got %h want %h", rw_q, 32'hA5A5_0000); end
        ncmp++; if (rw_qe !== 1'b0) begin nerr++;
            $display("FAIL reset_qe: got %b want 0", rw_qe); end
        ncmp++; if (rw_cnt !== 8'd0) begin nerr++;
            $display("FAIL reset_cnt: got %0d want 0", rw_cnt); end
        ncmp++; if (rw_co !== 1'b0) begin nerr++;
            $display("FAIL reset_coll: got %b want 0", rw_co); end
        ncmp++; if (ro_q !== 32'h0) begin nerr++;
            $display("FAIL reset_ro_q: got %h want 0", ro_q); end
        rst_n = 1'b1;
        drive(1'b0, 0, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (rw_q !== 32'hA5A5_0000) begin nerr++;
            $display("FAIL idle_hold_q: got %h want %h", rw_q, 32'hA5A5_0000); end
    endtask

    task automatic test_sw_hw_collision();
        drive(1'b1, 32'h1, 3'b110, 0, 32'h2, 32'h3, 1'b0);
        tick();
        ncmp++; if (rw_q !== 32'h1) begin nerr++;
            $display("FAIL swhw_q: got %h want 1", rw_q); end
        ncmp++; if (rw_qe !== 1'b1) begin nerr++;
            $display("FAIL swhw_qe: got %b want 1", rw_qe); end
        ncmp++; if (rw_co !== 1'b1) begin nerr++;
            $display("FAIL swhw_coll: got %b want 1", rw_co); end
        ncmp++; if (rw_cnt !== 8'd1) begin nerr++;
            $display("FAIL swhw_cnt: got %0d want 1", rw_cnt); end
        ncmp++; if (ro_q !== 32'h2) begin nerr++;
            $display("FAIL ro_ignore_we_q: got %h want 2", ro_q); end
        ncmp++; if (ro_qe !== 1'b0) begin nerr++;
            $display("FAIL ro_qe: got %b want 0", ro_qe); end
        ncmp++; if (ro_co !== 1'b1) begin nerr++;
            $display("FAIL ro_multi_coll: got %b want 1", ro_co); end
    endtask

    task automatic test_hw_priority();
        drive(1'b0, 0, 3'b110, 0, 32'h2, 32'h3, 1'b0);
        tick();
        ncmp++; if (rw_q !== 32'h2) begin nerr++;
            $display("FAIL prio_q: got %h want 2", rw_q); end
        ncmp++; if (rw_qe !== 1'b0) begin nerr++;
            $display("FAIL prio_qe: got %b want 0", rw_qe); end
        ncmp++; if (rw_co !== 1'b1) begin nerr++;
            $display("FAIL prio_coll: got %b want 1", rw_co); end
        ncmp++; if (rw_cnt !== 8'd2) begin nerr++;
            $display("FAIL prio_cnt: got %0d want 2", rw_cnt); end
        drive(1'b0, 0, 3'b101, 32'h77, 0, 32'h99, 1'b0);
        tick();
        ncmp++; if (rw_q !== 32'h77) begin nerr++;
            $display("FAIL prio0_q: got %h want 77", rw_q); end
        drive(1'b0, 0, 3'b001, 32'h77, 0, 0, 1'b0);
        tick();
        ncmp++; if (rw_co !== 1'b0) begin nerr++;
            $display("FAIL single_hw_coll: got %b want 0", rw_co); end
        ncmp++; if (rw_cnt !== 8'd3) begin nerr++;
            $display("FAIL single_hw_cnt: got %0d want 3", rw_cnt); end
        drive(1'b0, 0, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (rw_q !== 32'h77) begin nerr++;
            $display("FAIL hold_q: got %h want 77", rw_q); end
    endtask

    task automatic test_ro();
        drive(1'b1, 32'h1234, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (ro_q !== 32'h77) begin nerr++;
            $display("FAIL ro_swonly_q: got %h want 77", ro_q); end
        ncmp++; if (rw_q !== 32'h1234) begin nerr++;
            $display("FAIL rw_swonly_q: got %h want 1234", rw_q); end
        drive(1'b1, 32'h0, 3'b001, 32'h9, 0, 0, 1'b0);
        tick();
        ncmp++; if (ro_q !== 32'h9) begin nerr++;
            $display("FAIL ro_hw_q: got %h want 9", ro_q); end
        ncmp++; if (ro_co !== 1'b0) begin nerr++;
            $display("FAIL ro_swhw_coll: got %b want 0", ro_co); end
        ncmp++; if (rw_co !== 1'b1) begin nerr++;
            $display("FAIL rw_swhw_coll: got %b want 1", rw_co); end
        ncmp++; if (rw_q !== 32'h0) begin nerr++;
            $display("FAIL rw_sw_wins_q: got %h want 0", rw_q); end
    endtask

    task automatic test_w1s();
        drive(1'b0, 0, 3'b001, 32'hF0, 0, 0, 1'b0);
        tick();
        drive(1'b1, 32'h0F, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (s_q !== 32'hFF) begin nerr++;
            $display("FAIL w1s_q: got %h want ff", s_q); end
        ncmp++; if (s_qe !== 1'b1) begin nerr++;
            $display("FAIL w1s_qe: got %b want 1", s_qe); end
        drive(1'b1, 32'h100, 3'b001, 32'h3, 0, 0, 1'b0);
        tick();
        ncmp++; if (s_q !== 32'h103) begin nerr++;
            $display("FAIL w1s_hw_q: got %h want 103", s_q); end
    endtask

    task automatic test_w1c();
        drive(1'b0, 0, 3'b001, 32'hFF, 0, 0, 1'b0);
        tick();
        drive(1'b1, 32'h0F, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (c_q !== 32'hF0) begin nerr++;
            $display("FAIL w1c_q: got %h want f0", c_q); end
        drive(1'b1, 32'h0F, 3'b001, 32'h1FF, 0, 0, 1'b0);
        tick();
        ncmp++; if (c_q !== 32'h1F0) begin nerr++;
            $display("FAIL w1c_hw_q: got %h want 1f0", c_q); end
    endtask

    task automatic test_w0c();
        drive(1'b0, 0, 3'b001, 32'hFF, 0, 0, 1'b0);
        tick();
        drive(1'b1, 32'hFFFF_FF0F, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (z_q !== 32'h0F) begin nerr++;
            $display("FAIL w0c_q: got %h want 0f", z_q); end
        drive(1'b1, 32'hFFFF_FFF0, 3'b001, 32'h33, 0, 0, 1'b0);
        tick();
        ncmp++; if (z_q !== 32'h30) begin nerr++;
            $display("FAIL w0c_hw_q: got %h want 30", z_q); end
    endtask

    task automatic test_rc();
        drive(1'b0, 0, 3'b001, 32'h55, 0, 0, 1'b0);
        tick();
        drive(1'b1, 0, 3'b000, 0, 0, 0, 1'b0);
        #1;
        ncmp++; if (rc_qs !== 32'h55) begin nerr++;
            $display("FAIL rc_qs: got %h want 55", rc_qs); end
        tick();
        ncmp++; if (rc_q !== 32'h0) begin nerr++;
            $display("FAIL rc_q: got %h want 0", rc_q); end
        ncmp++; if (rc_qe !== 1'b1) begin nerr++;
            $display("FAIL rc_qe: got %b want 1", rc_qe); end
        drive(1'b0, 0, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (rc_qe !== 1'b0) begin nerr++;
            $display("FAIL rc_qe_drop: got %b want 0", rc_qe); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [4];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
        drive(1'b0, 0, 3'b000, 0, 0, 0, 1'b1);
        tick();
        ncmp++; if (sat_cnt !== 2'd0) begin nerr++;
            $display("FAIL sat_clr0: got %0d want 0", sat_cnt); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 3'b011, 32'h1, 32'h2, 0, 1'b0);
            tick();
            ncmp++; if (sat_cnt !== exp_cnt[i]) begin nerr++;
                $display("FAIL sat_cnt%0d: got %0d want %0d",
                         i, sat_cnt, exp_cnt[i]); end
            ncmp++; if (sat_co !== 1'b1) begin nerr++;
                $display("FAIL sat_coll%0d: got %b want 1", i, sat_co); end
        end
        drive(1'b0, 0, 3'b011, 32'h1, 32'h2, 0, 1'b1);
        tick();
        ncmp++; if (sat_cnt !== 2'd0) begin nerr++;
            $display("FAIL clr_wins_cnt: got %0d want 0", sat_cnt); end
        ncmp++; if (sat_co !== 1'b1) begin nerr++;
            $display("FAIL clr_wins_coll: got %b want 1", sat_co); end
        drive(1'b0, 0, 3'b000, 0, 0, 0, 1'b0);
        tick();
        ncmp++; if (sat_co !== 1'b0) begin nerr++;
            $display("FAIL coll_pulse_end: got %b want 0", sat_co); end
        ncmp++; if (sat_cnt !== 2'd0) begin nerr++;
            $display("FAIL cnt_after_clr: got %0d want 0", sat_cnt); end
    endtask

    initial begin
        test_reset();
        test_sw_hw_collision();
        test_hw_priority();
        test_ro();
        test_w1s();
        test_w1c();
        test_w0c();
        test_rc();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
